pgm_rd: RTL and testbench

Replay engine of the packet generator module (PGM). Once the write stage has stored a template packet in PGM_RAM and pulsed its start flag, this block reads the template back from PGM_RAM. It then emits the packet repeatedly, with a programmable inter-packet gap, as data + PHV on the standard 134-bit pipeline interface. When no generation is running, it forwards bypass traffic from the write stage.

---
 rtl/pgm_rd.sv | 258 +++++++++++++++++++++++++
 tb/tb_pgm_rd.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_rd.sv
// pgm_rd: replay engine of the packet generator module.
// Reads a template packet back from PGM_RAM after the write stage signals
// start, then emits it repeatedly with a programmable inter-packet gap as
// data + PHV on the 134-bit pipeline interface. When no generation is
// running, bypass traffic from the write stage is forwarded with one cycle
// of delay.
// Optional feature macro: PGM_RD_SEQ_EN stamps a per-packet sequence number
// into the header PHV and into bits [31:0] of the header data word.
module pgm_rd #(
  parameter int          RAM_AW  = 7,
  parameter logic [15:0] DEF_GAP = 16'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1023:0]     in_rd_phv,
  input  logic              in_rd_phv_wr,
  input  logic [133:0]      in_rd_data,
  input  logic              in_rd_data_wr,
  input  logic              in_rd_valid,
  input  logic              in_rd_valid_wr,
  output logic              out_rd_phv_alf,
  output logic              out_rd_alf,
  input  logic              in_pgm_bypass_flag,
  input  logic              in_pgm_sent_start_flag,
  input  logic              in_pgm_sent_finish_flag,
  output logic              rd2ram_rd_en,
  output logic [RAM_AW-1:0] rd2ram_addr,
  input  logic [143:0]      ram2rd_rdata,
  input  logic [31:0]       cfg_send_cnt,
  input  logic [15:0]       cfg_gap,
  output logic [1023:0]     out_rd_phv,
  output logic              out_rd_phv_wr,
  input  logic              in_rd_phv_alf,
  output logic [133:0]      out_rd_data,
  output logic              out_rd_data_wr,
  output logic              out_rd_valid,
  output logic              out_rd_valid_wr,
  input  logic              in_rd_alf,
  output logic              pgm_rd_busy,
  output logic [31:0]       sent_pkt_cnt,
  output logic [15:0]       byp_drop_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, READ, GAP} state_t;

  localparam logic [RAM_AW-1:0] ADDR_ZERO = '0;
  localparam logic [RAM_AW-1:0] ADDR_LAST = '1;
  localparam logic [1:0]        TAG_HDR   = 2'b01;
  localparam logic [1:0]        TAG_TAIL  = 2'b10;

  state_t            state;
  state_t            state_nxt;

  logic [RAM_AW-1:0] rd_addr;
  logic [RAM_AW-1:0] pend_addr;
  logic              rd_en;
  logic              rd_issued_last;
  logic              rd_pend;
  logic              rd_pend2;

  logic              fin_lat;
  logic              fin_any;
  logic              byp_open;
  logic              arm_ready;
  logic              send_done;
  logic [15:0]       gap_cnt;
  logic [15:0]       gap_len;

  logic              word_vld;
  logic              word_hdr;
  logic              hdr_bad;
  logic              word_emit;
  logic              word_tail;
  logic [1:0]        word_tag;
  logic [1:0]        gen_tag;
  logic [133:0]      gen_data;
  logic [1023:0]     gen_phv;
  logic [9:0]        unused_rdata_hi;

  // The almost-full flags are handed straight upstream.
  assign out_rd_phv_alf  = in_rd_phv_alf;
  assign out_rd_alf      = in_rd_alf;
  assign unused_rdata_hi = ram2rd_rdata[143:134];

  assign fin_any   = in_pgm_sent_finish_flag | fin_lat;
  assign arm_ready = ~in_rd_alf & ~in_rd_phv_alf & ~in_pgm_bypass_flag & ~byp_open;
  assign gap_len   = (cfg_gap == 16'd0) ? DEF_GAP : cfg_gap;
  assign send_done = (cfg_send_cnt != 32'd0) && (sent_pkt_cnt == cfg_send_cnt);

  // A returned RAM word is only meaningful while still reading; the one
  // speculative read issued in the tail cycle lands after READ is left.
  assign word_vld  = rd_pend && (state == READ);
  assign word_tag  = ram2rd_rdata[133:132];
  assign word_hdr  = (pend_addr == ADDR_ZERO);
  assign hdr_bad   = word_vld && word_hdr && (word_tag != TAG_HDR);
  assign word_emit = word_vld && !hdr_bad;
  assign word_tail = word_emit && ((word_tag == TAG_TAIL) || (pend_addr == ADDR_LAST));
  assign gen_tag   = word_tail ? TAG_TAIL : word_tag;

`ifdef PGM_RD_SEQ_EN
  assign gen_data = word_hdr ? {gen_tag, ram2rd_rdata[131:32], sent_pkt_cnt}
                             : {gen_tag, ram2rd_rdata[131:0]};
  assign gen_phv  = word_hdr ? {992'd0, sent_pkt_cnt} : '0;
`else
  assign gen_data = {gen_tag, ram2rd_rdata[131:0]};
  assign gen_phv  = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: arm on start, read until the tail, gap, then re-arm or stop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_pgm_sent_start_flag && !in_pgm_sent_finish_flag) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (fin_any) begin
          state_nxt = IDLE;
        end else if (arm_ready) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (hdr_bad) begin
          state_nxt = IDLE;
        end else if (word_tail) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (fin_any) begin
          state_nxt = IDLE;
        end else if (gap_cnt == gap_len) begin
          state_nxt = send_done ? IDLE : ARM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: RAM read strobe and busy (held while reads drain).
  always_comb begin
    rd_en       = (state == READ) && !rd_issued_last;
    pgm_rd_busy = (state != IDLE) || rd_pend || rd_pend2;
  end

  assign rd2ram_rd_en = rd_en;
  assign rd2ram_addr  = rd_addr;

  // Read address walk, never wrapping past the last RAM word, plus the read-return tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr        <= '0;
      rd_issued_last <= 1'b0;
      rd_pend        <= 1'b0;
      rd_pend2       <= 1'b0;
      pend_addr      <= '0;
    end else begin
      rd_pend   <= rd_en;
      rd_pend2  <= rd_pend;
      pend_addr <= rd_addr;
      if (state != READ) begin
        rd_addr        <= '0;
        rd_issued_last <= 1'b0;
      end else if (rd_en) begin
        if (rd_addr == ADDR_LAST) begin
          rd_issued_last <= 1'b1;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  // Finish latch, open-bypass tracking, gap timer and the two status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_lat      <= 1'b0;
      byp_open     <= 1'b0;
      gap_cnt      <= 16'd0;
      sent_pkt_cnt <= 32'd0;
      byp_drop_cnt <= 16'd0;
    end else begin
      if (state == IDLE) begin
        fin_lat <= 1'b0;
      end else if (in_pgm_sent_finish_flag) begin
        fin_lat <= 1'b1;
      end

      if (in_rd_valid_wr) begin
        byp_open <= 1'b0;
      end else if ((state == IDLE) && in_rd_data_wr) begin
        byp_open <= 1'b1;
      end

      if (state != GAP) begin
        gap_cnt <= 16'd0;
      end else begin
        gap_cnt <= gap_cnt + 16'd1;
      end

      if ((state == IDLE) && (state_nxt == ARM)) begin
        sent_pkt_cnt <= 32'd0;
      end else if (word_tail) begin
        sent_pkt_cnt <= sent_pkt_cnt + 32'd1;
      end

      if ((state != IDLE) && in_rd_data_wr && (byp_drop_cnt != 16'hFFFF)) begin
        byp_drop_cnt <= byp_drop_cnt + 16'd1;
      end
    end
  end

  // Output register: bypass words while idle, template words while reading, otherwise quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_rd_phv      <= '0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_data     <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
    end else if (state == IDLE) begin
      out_rd_phv      <= in_rd_phv;
      out_rd_phv_wr   <= in_rd_phv_wr;
      out_rd_data     <= in_rd_data;
      out_rd_data_wr  <= in_rd_data_wr;
      out_rd_valid    <= in_rd_valid;
      out_rd_valid_wr <= in_rd_valid_wr;
    end else if (word_emit) begin
      out_rd_phv      <= gen_phv;
      out_rd_phv_wr   <= word_hdr;
      out_rd_data     <= gen_data;
      out_rd_data_wr  <= 1'b1;
      out_rd_valid    <= word_tail;
      out_rd_valid_wr <= word_tail;
    end else begin
      out_rd_phv      <= '0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_data     <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pgm_rd.sv
// tb_pgm_rd: directed self-checking bench for pgm_rd with a behavioural
// 1-cycle-latency PGM_RAM and an output-word recorder.
module tb_pgm_rd;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1023:0] in_rd_phv = '0;
  logic          in_rd_phv_wr = 1'b0;
  logic [133:0]  in_rd_data = '0;
  logic          in_rd_data_wr = 1'b0;
  logic          in_rd_valid = 1'b0;
  logic          in_rd_valid_wr = 1'b0;
  logic          out_rd_phv_alf;
  logic          out_rd_alf;
  logic          in_pgm_bypass_flag = 1'b0;
  logic          in_pgm_sent_start_flag = 1'b0;
  logic          in_pgm_sent_finish_flag = 1'b0;
  logic          rd2ram_rd_en;
  logic [AW-1:0] rd2ram_addr;
  logic [143:0]  ram2rd_rdata = '0;
  logic [31:0]   cfg_send_cnt = '0;
  logic [15:0]   cfg_gap = '0;
  logic [1023:0] out_rd_phv;
  logic          out_rd_phv_wr;
  logic          in_rd_phv_alf = 1'b0;
  logic [133:0]  out_rd_data;
  logic          out_rd_data_wr;
  logic          out_rd_valid;
  logic          out_rd_valid_wr;
  logic          in_rd_alf = 1'b0;
  logic          pgm_rd_busy;
  logic [31:0]   sent_pkt_cnt;
  logic [15:0]   byp_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pgm_rd #(.RAM_AW(AW), .DEF_GAP(16'd16)) dut (
    .clk(clk), .rst(rst),
    .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr),
    .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
    .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr),
    .out_rd_phv_alf(out_rd_phv_alf), .out_rd_alf(out_rd_alf),
    .in_pgm_bypass_flag(in_pgm_bypass_flag),
    .in_pgm_sent_start_flag(in_pgm_sent_start_flag),
    .in_pgm_sent_finish_flag(in_pgm_sent_finish_flag),
    .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr),
    .ram2rd_rdata(ram2rd_rdata),
    .cfg_send_cnt(cfg_send_cnt), .cfg_gap(cfg_gap),
    .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
    .in_rd_phv_alf(in_rd_phv_alf),
    .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
    .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
    .in_rd_alf(in_rd_alf), .pgm_rd_busy(pgm_rd_busy),
    .sent_pkt_cnt(sent_pkt_cnt), .byp_drop_cnt(byp_drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural PGM_RAM with one cycle of read latency.
  logic [143:0] mem [0:127];
  always @(posedge clk) begin
    if (rd2ram_rd_en) ram2rd_rdata <= mem[rd2ram_addr];
  end

  // Cycle counter; tasks and the recorder read it away from the posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder sampling on the falling edge.
  logic [133:0]  mon_data  [$];
  int            mon_cyc   [$];
  logic          mon_phvwr [$];
  logic          mon_vwr   [$];
  logic          mon_valid [$];
  logic [1023:0] mon_phv   [$];
  int            first_rd = -1;

  always @(negedge clk) begin
    if (out_rd_data_wr === 1'b1) begin
      mon_data.push_back(out_rd_data);
      mon_cyc.push_back(cyc);
      mon_phvwr.push_back(out_rd_phv_wr);
      mon_vwr.push_back(out_rd_valid_wr);
      mon_valid.push_back(out_rd_valid);
      mon_phv.push_back(out_rd_phv);
    end
    if ((rd2ram_rd_en === 1'b1) && (first_rd < 0)) first_rd = cyc;
  end

  function automatic logic [143:0] mk(input logic [1:0] tag, input logic [31:0] lo);
    return {10'd0, tag, lo, ~lo, lo, 4'h3, lo};
  endfunction

  // Expected emitted word: the stored word, with the sequence stamp on headers when enabled.
  function automatic logic [133:0] exp_word(input logic [143:0] m, input bit hdr, input int k);
    logic [133:0] r;
    r = m[133:0];
`ifdef PGM_RD_SEQ_EN
    if (hdr) r[31:0] = k;
`else
    if (hdr && (k < 0)) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [1023:0] exp_phv(input int k);
`ifdef PGM_RD_SEQ_EN
    return {992'd0, 32'(k)};
`else
    return (k < 0) ? '1 : '0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_cyc.delete(); mon_phvwr.delete();
    mon_vwr.delete(); mon_valid.delete(); mon_phv.delete();
    first_rd = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_rd_phv = '0; in_rd_phv_wr = 0; in_rd_data = '0; in_rd_data_wr = 0;
    in_rd_valid = 0; in_rd_valid_wr = 0; in_pgm_bypass_flag = 0;
    in_pgm_sent_start_flag = 0; in_pgm_sent_finish_flag = 0;
    in_rd_alf = 0; in_rd_phv_alf = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    clear_mon();
  endtask

  // 4-word template 01,11,11,10; the rest of RAM holds body words.
  task automatic load_std(input logic [31:0] base);
    for (int i = 0; i < 128; i++) mem[i] = mk(2'b11, base + i);
    mem[0] = mk(2'b01, base);
    mem[3] = mk(2'b10, base + 3);
  endtask

  task automatic pulse_start(output int s);
    s = cyc;
    in_pgm_sent_start_flag = 1'b1;
    tick(1);
    in_pgm_sent_start_flag = 1'b0;
  endtask

  task automatic test_reset();
    int s;
    do_reset();
    n_cmp++; if (out_rd_data_wr !== 1'b0) begin n_err++; $display("[TB] FAIL reset_data_wr: got %b want 0", out_rd_data_wr); end
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", pgm_rd_busy); end
    n_cmp++; if (sent_pkt_cnt !== 32'd0) begin n_err++; $display("[TB] FAIL reset_sent: got %0d want 0", sent_pkt_cnt); end
    n_cmp++; if (byp_drop_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_drop: got %0d want 0", byp_drop_cnt); end
    n_cmp++; if (rd2ram_rd_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rden: got %b want 0", rd2ram_rd_en); end
    // Reset in the middle of a packet.
    load_std(32'h1000_0000);
    cfg_send_cnt = 32'd0; cfg_gap = 16'd5;
    pulse_start(s);
    tick(2);
    in_rd_data = 134'h2A; in_rd_data_wr = 1'b1;
    tick(1);
    in_rd_data_wr = 1'b0;
    tick(1);
    n_cmp++; if (byp_drop_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL midreset_drop_before: got %0d want 1", byp_drop_cnt); end
    rst = 1'b1;
    tick(2);
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_busy: got %b want 0", pgm_rd_busy); end
    n_cmp++; if (byp_drop_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL midreset_drop: got %0d want 0", byp_drop_cnt); end
    n_cmp++; if (out_rd_phv_wr !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_phv_wr: got %b want 0", out_rd_phv_wr); end
    rst = 1'b0;
    tick(10);
    n_cmp++; if (mon_data.size() !== 2) begin n_err++; $display("[TB] FAIL midreset_words: got %0d want 2", mon_data.size()); end
    for (int i = 0; i < mon_vwr.size(); i++) begin
      n_cmp++; if (mon_vwr[i] !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_no_tail[%0d]: got %b want 0", i, mon_vwr[i]); end
    end
  endtask

  task automatic test_burst();
    int s, n, k, w;
    do_reset();
    load_std(32'hCAFE_0000);
    cfg_send_cnt = 32'd3; cfg_gap = 16'd5;
    pulse_start(s);
    tick(60);
    n_cmp++; if (first_rd - s !== 2) begin n_err++; $display("[TB] FAIL burst_start_to_rden: got %0d want 2", first_rd - s); end
    n_cmp++; if (mon_data.size() !== 12) begin n_err++; $display("[TB] FAIL burst_words: got %0d want 12", mon_data.size()); end
    n = (mon_data.size() < 12) ? mon_data.size() : 12;
    for (int i = 0; i < n; i++) begin
      k = i / 4; w = i % 4;
      n_cmp++; if (mon_cyc[i] !== s + 4 + 12 * k + w) begin n_err++; $display("[TB] FAIL burst_cycle[%0d]: got %0d want %0d", i, mon_cyc[i] - s, 4 + 12 * k + w); end
      n_cmp++; if (mon_data[i] !== exp_word(mem[w], w == 0, k)) begin n_err++; $display("[TB] FAIL burst_data[%0d]: got %h want %h", i, mon_data[i], exp_word(mem[w], w == 0, k)); end
      n_cmp++; if (mon_phvwr[i] !== (w == 0)) begin n_err++; $display("[TB] FAIL burst_phv_wr[%0d]: got %b want %b", i, mon_phvwr[i], w == 0); end
      n_cmp++; if (mon_vwr[i] !== (w == 3)) begin n_err++; $display("[TB] FAIL burst_valid_wr[%0d]: got %b want %b", i, mon_vwr[i], w == 3); end
    end
    n_cmp++; if (sent_pkt_cnt !== 32'd3) begin n_err++; $display("[TB] FAIL burst_sent: got %0d want 3", sent_pkt_cnt); end
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL burst_idle: got %b want 0", pgm_rd_busy); end
  endtask

  task automatic test_finish();
    int s;
    do_reset();
    load_std(32'h2000_0000);
    cfg_send_cnt = 32'd0; cfg_gap = 16'd5;
    pulse_start(s);
    tick(16);
    in_pgm_sent_finish_flag = 1'b1;
    tick(1);
    in_pgm_sent_finish_flag = 1'b0;
    tick(40);
    n_cmp++; if (mon_data.size() !== 8) begin n_err++; $display("[TB] FAIL finish_words: got %0d want 8", mon_data.size()); end
    if (mon_data.size() >= 8) begin
      n_cmp++; if (mon_cyc[4] !== s + 16) begin n_err++; $display("[TB] FAIL finish_hdr2_cycle: got %0d want 16", mon_cyc[4] - s); end
      n_cmp++; if (mon_vwr[7] !== 1'b1) begin n_err++; $display("[TB] FAIL finish_tail2: got %b want 1", mon_vwr[7]); end
    end
    n_cmp++; if (sent_pkt_cnt !== 32'd2) begin n_err++; $display("[TB] FAIL finish_sent: got %0d want 2", sent_pkt_cnt); end
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL finish_idle: got %b want 0", pgm_rd_busy); end
  endtask

  task automatic test_backpressure();
    int s, d;
    do_reset();
    load_std(32'h3000_0000);
    cfg_send_cnt = 32'd1; cfg_gap = 16'd5;
    in_rd_alf = 1'b1;
    pulse_start(s);
    n_cmp++; if (out_rd_alf !== 1'b1) begin n_err++; $display("[TB] FAIL bp_alf_passthru: got %b want 1", out_rd_alf); end
    tick(19);
    d = cyc;
    in_rd_alf = 1'b0;
    tick(20);
    n_cmp++; if (first_rd !== d + 1) begin n_err++; $display("[TB] FAIL bp_first_rden: got %0d want %0d", first_rd - s, d + 1 - s); end
    n_cmp++; if (mon_data.size() !== 4) begin n_err++; $display("[TB] FAIL bp_words: got %0d want 4", mon_data.size()); end
    if (mon_data.size() > 0) begin
      n_cmp++; if (mon_cyc[0] !== d + 3) begin n_err++; $display("[TB] FAIL bp_hdr_after_alf: got %0d want 3", mon_cyc[0] - d); end
    end
    n_cmp++; if (sent_pkt_cnt !== 32'd1) begin n_err++; $display("[TB] FAIL bp_sent: got %0d want 1", sent_pkt_cnt); end
  endtask

  task automatic test_bypass();
    logic [133:0]  bw [3];
    logic [1023:0] bphv;
    int b, s;
    do_reset();
    bw[0] = {2'b01, 100'hABC, 32'h1111_0001};
    bw[1] = {2'b11, 100'hDEF, 32'h2222_0002};
    bw[2] = {2'b10, 100'h123, 32'h3333_0003};
    bphv  = {32'h5A5A_5A5A, 960'd0, 32'h8765_4321};
    b = cyc;
    for (int i = 0; i < 3; i++) begin
      in_rd_data = bw[i]; in_rd_data_wr = 1'b1;
      in_rd_phv = (i == 0) ? bphv : '0; in_rd_phv_wr = (i == 0);
      in_rd_valid = (i == 2); in_rd_valid_wr = (i == 2);
      tick(1);
    end
    in_rd_data_wr = 0; in_rd_phv_wr = 0; in_rd_valid = 0; in_rd_valid_wr = 0;
    tick(3);
    n_cmp++; if (mon_data.size() !== 3) begin n_err++; $display("[TB] FAIL byp_words: got %0d want 3", mon_data.size()); end
    for (int i = 0; i < ((mon_data.size() < 3) ? mon_data.size() : 3); i++) begin
      n_cmp++; if (mon_data[i] !== bw[i]) begin n_err++; $display("[TB] FAIL byp_data[%0d]: got %h want %h", i, mon_data[i], bw[i]); end
      n_cmp++; if (mon_cyc[i] !== b + 1 + i) begin n_err++; $display("[TB] FAIL byp_latency[%0d]: got %0d want %0d", i, mon_cyc[i] - b, 1 + i); end
    end
    if (mon_data.size() >= 3) begin
      n_cmp++; if ((mon_phvwr[0] !== 1'b1) || (mon_phv[0] !== bphv)) begin n_err++; $display("[TB] FAIL byp_phv: got wr=%b phv_lo=%h want wr=1 phv_lo=%h", mon_phvwr[0], mon_phv[0][31:0], bphv[31:0]); end
      n_cmp++; if ((mon_vwr[2] !== 1'b1) || (mon_valid[2] !== 1'b1)) begin n_err++; $display("[TB] FAIL byp_valid: got %b/%b want 1/1", mon_valid[2], mon_vwr[2]); end
    end
    // Bypass words arriving during generation are dropped.
    load_std(32'h4000_0000);
    cfg_send_cnt = 32'd1; cfg_gap = 16'd5;
    clear_mon();
    pulse_start(s);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      in_rd_data = bw[i]; in_rd_data_wr = 1'b1; in_rd_valid_wr = (i == 2);
      tick(1);
    end
    in_rd_data_wr = 0; in_rd_valid_wr = 0;
    tick(30);
    n_cmp++; if (byp_drop_cnt !== 16'd3) begin n_err++; $display("[TB] FAIL drop_cnt: got %0d want 3", byp_drop_cnt); end
    n_cmp++; if (mon_data.size() !== 4) begin n_err++; $display("[TB] FAIL drop_words: got %0d want 4", mon_data.size()); end
    if (mon_data.size() >= 2) begin
      n_cmp++; if (mon_data[0] !== exp_word(mem[0], 1, 0)) begin n_err++; $display("[TB] FAIL drop_hdr: got %h want %h", mon_data[0], exp_word(mem[0], 1, 0)); end
      n_cmp++; if (mon_data[1] !== mem[1][133:0]) begin n_err++; $display("[TB] FAIL drop_body: got %h want %h", mon_data[1], mem[1][133:0]); end
    end
  endtask

  task automatic test_no_tail();
    int s;
    logic [133:0] last_exp;
    do_reset();
    for (int i = 0; i < 128; i++) mem[i] = mk(2'b11, 32'h5000_0000 + i);
    mem[0] = mk(2'b01, 32'h5000_0000);
    last_exp = {2'b10, mem[127][131:0]};
    cfg_send_cnt = 32'd1; cfg_gap = 16'd0;
    pulse_start(s);
    tick(170);
    n_cmp++; if (mon_data.size() !== 128) begin n_err++; $display("[TB] FAIL notail_words: got %0d want 128", mon_data.size()); end
    if (mon_data.size() >= 128) begin
      n_cmp++; if (mon_data[127] !== last_exp) begin n_err++; $display("[TB] FAIL notail_last: got %h want %h", mon_data[127], last_exp); end
      n_cmp++; if (mon_vwr[127] !== 1'b1) begin n_err++; $display("[TB] FAIL notail_valid_wr: got %b want 1", mon_vwr[127]); end
      n_cmp++; if (mon_data[64] !== mem[64][133:0]) begin n_err++; $display("[TB] FAIL notail_mid: got %h want %h", mon_data[64], mem[64][133:0]); end
      n_cmp++; if (mon_cyc[127] !== s + 131) begin n_err++; $display("[TB] FAIL notail_last_cycle: got %0d want 131", mon_cyc[127] - s); end
    end
    n_cmp++; if (sent_pkt_cnt !== 32'd1) begin n_err++; $display("[TB] FAIL notail_sent: got %0d want 1", sent_pkt_cnt); end
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL notail_idle: got %b want 0", pgm_rd_busy); end
  endtask

  task automatic test_bad_header();
    int s;
    do_reset();
    load_std(32'h6000_0000);
    mem[0] = mk(2'b11, 32'h6000_0000);
    cfg_send_cnt = 32'd1; cfg_gap = 16'd5;
    pulse_start(s);
    tick(10);
    n_cmp++; if (mon_data.size() !== 0) begin n_err++; $display("[TB] FAIL badhdr_words: got %0d want 0", mon_data.size()); end
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL badhdr_idle: got %b want 0", pgm_rd_busy); end
    n_cmp++; if (sent_pkt_cnt !== 32'd0) begin n_err++; $display("[TB] FAIL badhdr_sent: got %0d want 0", sent_pkt_cnt); end
    in_rd_data = 134'h77; in_rd_data_wr = 1'b1; in_rd_valid_wr = 1'b1;
    tick(1);
    in_rd_data_wr = 1'b0; in_rd_valid_wr = 1'b0;
    tick(2);
    n_cmp++; if (mon_data.size() !== 1) begin n_err++; $display("[TB] FAIL badhdr_bypass_after: got %0d want 1", mon_data.size()); end
  endtask

  task automatic test_start_finish();
    int s;
    do_reset();
    load_std(32'h7000_0000);
    cfg_send_cnt = 32'd1; cfg_gap = 16'd5;
    in_pgm_sent_finish_flag = 1'b1;
    pulse_start(s);
    in_pgm_sent_finish_flag = 1'b0;
    n_cmp++; if (pgm_rd_busy !== 1'b0) begin n_err++; $display("[TB] FAIL startfin_busy: got %b want 0", pgm_rd_busy); end
    tick(12);
    n_cmp++; if (mon_data.size() !== 0) begin n_err++; $display("[TB] FAIL startfin_words: got %0d want 0", mon_data.size()); end
  endtask

  task automatic test_seq();
    int s;
    do_reset();
    load_std(32'hDEAD_BEEF);
    cfg_send_cnt = 32'd2; cfg_gap = 16'd3;
    pulse_start(s);
    tick(50);
    n_cmp++; if (mon_data.size() !== 8) begin n_err++; $display("[TB] FAIL seq_words: got %0d want 8", mon_data.size()); end
    if (mon_data.size() >= 8) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (mon_phv[4 * k] !== exp_phv(k)) begin n_err++; $display("[TB] FAIL seq_phv[%0d]: got lo %h want lo %h", k, mon_phv[4 * k][31:0], exp_phv(k) & 1024'hFFFF_FFFF); end
        n_cmp++; if (mon_data[4 * k] !== exp_word(mem[0], 1, k)) begin n_err++; $display("[TB] FAIL seq_hdr_data[%0d]: got %h want %h", k, mon_data[4 * k], exp_word(mem[0], 1, k)); end
      end
      n_cmp++; if (mon_cyc[4] !== s + 14) begin n_err++; $display("[TB] FAIL seq_hdr2_cycle: got %0d want 14", mon_cyc[4] - s); end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_finish();
    test_backpressure();
    test_bypass();
    test_no_tail();
    test_bad_header();
    test_start_finish();
    test_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
